esdi_sector_framer: RTL
=======================

Name: esdi_sector_framer

Overview:
- Consumes the raw byte stream from the ESDI read datapath. That stream is unaligned to the recorded data.
- Hunts for the sync byte at any bit offset and realigns all following bytes to it.
- Extracts one header field or one data field, strips the trailing CRC-16 and forwards the field bytes on an AXI-Stream to the sector buffer.
- Reports completion, CRC error and sync timeout to the controller.

Parameters:
- SYNC_BYTE, 8'hA1, sync/address-mark pattern; MSB is the first bit received.
- HEADER_BYTES, 4, header field length excluding CRC; range 1..1023.
- DATA_BYTES, 512, data field length excluding CRC; range 1..1023.
- SYNC_TIMEOUT, 32, number of input bytes accepted in HUNT before giving up; range 1..255.

Ports:
- csr_aclk  in  1  clock.
- csr_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; low forces IDLE.
- field_start  in  1  one-cycle pulse; arms a hunt.
- field_is_data  in  1  sampled with field_start; 1 selects DATA_BYTES, 0 selects HEADER_BYTES.
- in_tvalid  in  1  upstream byte valid.
- in_tready  out  1  upstream ready.
- in_tdata  in  8  upstream byte; MSB is the earliest bit.
- out_tvalid  out  1  field byte valid.
- out_tready  in  1  downstream ready.
- out_tdata  out  8  aligned field byte.
- out_tlast  out  1  marks the last field byte.
- out_tuser  out  1  1 = data field, 0 = header field.
- field_done  out  1  one-cycle pulse after the second CRC byte is consumed.
- crc_error  out  1  CRC result; valid from field_done until the next field_start.
- sync_timeout  out  1  one-cycle pulse when HUNT expires.

Behaviour:
- Single clock domain, csr_aclk. Reset is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - Window register sr[15:0] = 0.
  - out_tvalid, out_tlast, out_tuser, field_done, crc_error, sync_timeout = 0; out_tdata = 0.
- Input acceptance: a byte is accepted when in_tvalid && in_tready.
  - in_tready = 1 in IDLE, HUNT, CRC1 and CRC2.
  - in_tready = (!out_tvalid || out_tready) in FIELD.
  - Bytes accepted in IDLE are discarded.
- Window: on each accepted byte, sr <= {sr[7:0], in_tdata}.
- States:
  - IDLE -> HUNT on field_start && enable. On that transition:
    - sr cleared.
    - Byte counter cleared.
    - crc_error cleared.
    - Length latched from field_is_data; out_tuser latched.
  - HUNT: evaluate candidates sr'[k+7:k], k = 0..7, where sr' is the post-shift window.
    - On a match, latch the highest matching k as the alignment offset (the earliest arriving pattern), init CRC to 16'hFFFF, clear the counter, go to FIELD.
    - Otherwise increment the counter. When the counter reaches SYNC_TIMEOUT, pulse sync_timeout and go to IDLE.
  - FIELD: each accepted byte produces aligned byte sr'[k+7:k].
    - That byte is registered to out_tdata with out_tvalid=1 in the following cycle (1-cycle latency).
    - The CRC is updated with it.
    - out_tlast=1 on byte index length-1, then go to CRC1.
  - CRC1 -> CRC2 -> IDLE: each consumes one aligned byte into the CRC and does not forward it.
    - On leaving CRC2, pulse field_done.
    - crc_error <= (CRC residue != 0).
- CRC: CRC-16-CCITT, poly 16'h1021, init 16'hFFFF, MSB-first, no reflection, no final XOR.
  - Covers the field bytes and both CRC bytes; the sync byte is excluded.
  - Good field leaves residue 0.
- Output stage: a single register.
  - out_tvalid holds until out_tready; out_tdata and out_tlast are stable while out_tvalid=1 && !out_tready.
  - Never drops or duplicates a byte.
- Counter width: 10 bits, compared against length-1. No wrap: the state exits at the terminal count.
- Simultaneous events:
  - field_start in any non-IDLE state aborts the current field. Re-arm exactly as from IDLE; no field_done is issued for the aborted field.
  - A pending output byte (out_tvalid=1) is still delivered, with its original out_tlast.
  - enable low takes priority over field_start: go to IDLE the same cycle, with no field_done and no sync_timeout. A pending output byte is still delivered.
  - A timeout and a match on the same byte: the match wins.
- Reset asserted mid-field: all outputs return to their reset values immediately; no partial handshake is completed.

Test Plan:
1. Aligned header: override HEADER_BYTES=9 and send 0xA1, "123456789", 0x29, 0xB1 with out_tready=1.
   -> 9 bytes 0x31..0x39 out, tlast on 0x39, tuser=0, field_done=1, crc_error=0.
2. Bit offset 3: the same stream pre-shifted by 3 bits, with 3 filler 1-bits before it and the tail padded.
   -> identical output bytes, crc_error=0.
3. Corrupt CRC: as scenario 1 but last byte 0xB0 -> all 9 bytes delivered, field_done pulse with crc_error=1.
4. Timeout: SYNC_TIMEOUT=32, 32 bytes of 0x00 after field_start.
   -> sync_timeout pulses after the 32nd accepted byte, state IDLE, no out_tvalid.
5. Backpressure: data field of 512 bytes with out_tready toggling at random, about 50%.
   -> 512 bytes in order with no loss; in_tready low whenever out_tvalid && !out_tready; tuser=1 throughout.
6. Abort: field_start again at header byte 2.
   -> pending byte still delivered, no field_done; the new hunt finds the next sync and completes normally.

Source files
------------

// File: rtl/esdi_sector_framer.sv
//------------------------------------------------------------------------------
// esdi_sector_framer
// Bit-aligns the ESDI read stream on the sync byte, forwards one header or
// data field on AXI-Stream, and checks the trailing CRC-16-CCITT.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module esdi_sector_framer #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA1,
  parameter int         HEADER_BYTES = 4,
  parameter int         DATA_BYTES   = 512,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       csr_aclk,
  input  logic       csr_aresetn,
  input  logic       enable,
  input  logic       field_start,
  input  logic       field_is_data,
  input  logic       in_tvalid,
  output logic       in_tready,
  input  logic [7:0] in_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic [7:0] out_tdata,
  output logic       out_tlast,
  output logic       out_tuser,
  output logic       field_done,
  output logic       crc_error,
  output logic       sync_timeout
);

  localparam logic [9:0] c_HDR_LAST = 10'(HEADER_BYTES - 1);
  localparam logic [9:0] c_DAT_LAST = 10'(DATA_BYTES - 1);
  localparam logic [9:0] c_TO_LAST  = 10'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HUNT  = 3'd1,
    S_FIELD = 3'd2,
    S_CRC1  = 3'd3,
    S_CRC2  = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_prev;
  logic [9:0]  r_cnt;
  logic [9:0]  r_len_m1;
  logic [2:0]  r_off;
  logic [15:0] r_crc;

  logic [15:0] w_win;
  logic        w_unused;
  logic        w_acc;
  logic        w_hit;
  logic [2:0]  w_hit_off;
  logic [7:0]  w_aligned;
  logic [15:0] w_crc_next;

  function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Post-shift window: previous byte above the incoming one.
  assign w_win      = {r_prev, in_tdata};
  assign w_unused   = w_win[15];
  assign in_tready  = (r_state == S_FIELD) ? (!out_tvalid || out_tready) : 1'b1;
  assign w_acc      = in_tvalid && in_tready;
  assign w_aligned  = w_win[r_off +: 8];
  assign w_crc_next = f_crc_byte(r_crc, w_aligned);

  // Later (higher) offsets override: the highest k is the earliest-arriving pattern.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_off = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (w_win[k +: 8] == SYNC_BYTE) begin
        w_hit     = 1'b1;
        w_hit_off = 3'(k);
      end
    end
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_cnt        <= '0;
      r_len_m1     <= '0;
      r_off        <= '0;
      r_crc        <= 16'hFFFF;
      out_tvalid   <= 1'b0;
      out_tdata    <= '0;
      out_tlast    <= 1'b0;
      out_tuser    <= 1'b0;
      field_done   <= 1'b0;
      crc_error    <= 1'b0;
      sync_timeout <= 1'b0;
    end else begin
      field_done   <= 1'b0;
      sync_timeout <= 1'b0;

      if (out_tvalid && out_tready) begin
        out_tvalid <= 1'b0;
        out_tlast  <= 1'b0;
      end

      if (w_acc) begin
        r_prev <= in_tdata;
      end

      if (!enable) begin
        r_state <= S_IDLE;
      end else if (field_start) begin
        r_state   <= S_HUNT;
        r_prev    <= '0;
        r_cnt     <= '0;
        crc_error <= 1'b0;
        r_len_m1  <= field_is_data ? c_DAT_LAST : c_HDR_LAST;
        out_tuser <= field_is_data;
      end else if (w_acc) begin
        case (r_state)
          S_HUNT: begin
            if (w_hit) begin
              r_off   <= w_hit_off;
              r_crc   <= 16'hFFFF;
              r_cnt   <= '0;
              r_state <= S_FIELD;
            end else if (r_cnt == c_TO_LAST) begin
              sync_timeout <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 10'd1;
            end
          end
          S_FIELD: begin
            out_tdata  <= w_aligned;
            out_tvalid <= 1'b1;
            out_tlast  <= (r_cnt == r_len_m1);
            r_crc      <= w_crc_next;
            r_cnt      <= r_cnt + 10'd1;
            if (r_cnt == r_len_m1) begin
              r_state <= S_CRC1;
            end
          end
          S_CRC1: begin
            r_crc   <= w_crc_next;
            r_state <= S_CRC2;
          end
          S_CRC2: begin
            r_crc      <= w_crc_next;
            crc_error  <= (w_crc_next != 16'h0000);
            field_done <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
